conv_race_monitor: RTL and testbench

- Synthesizable, parametrised successor to the two-DUT L3 active/frozen convergence comparison.
- Watches NCH error channels, e.g. several pst_2layer instances with different l3_freeze/eta settings, on the shared gamma_oscillator cycle_start.
- Records each channel's convergence cycle, with a hold (streak) requirement and a timeout.
- After all channels settle, computes integer percent speedup of each channel versus a reference channel using a shared sequential divider.
- Re-armable for successive stimulus epochs (pattern change, re-adaptation).

---
 rtl/conv_race_monitor_if.sv | 38 +++
 rtl/conv_race_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_conv_race_monitor.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_race_monitor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_race_monitor_if
// Brief    : Bus bundle for conv_race_monitor: epoch tick, rearm, threshold
//            and per-channel errors in; convergence results and speedups out.
// Revision : 1.0 - initial release
// ============================================================================
interface conv_race_monitor_if #(
  parameter int NCH = 2,
  parameter int EW  = 8,
  parameter int CW  = 12
);
  logic                 cycle_start;
  logic                 rearm;
  logic [EW-1:0]        conv_th;
  logic [NCH*EW-1:0]    err_bus;
  logic [CW-1:0]        epoch;
  logic [NCH*CW-1:0]    conv_cyc_bus;
  logic [NCH-1:0]       converged;
  logic [NCH-1:0]       timed_out;
  logic                 all_done;
  logic [NCH*7-1:0]     pct_bus;
  logic                 pct_valid;

  // Stimulus side: drives epoch tick, rearm, threshold and errors.
  modport master (
    output cycle_start, rearm, conv_th, err_bus,
    input  epoch, conv_cyc_bus, converged, timed_out, all_done, pct_bus, pct_valid
  );

  // Monitor side.
  modport slave (
    input  cycle_start, rearm, conv_th, err_bus,
    output epoch, conv_cyc_bus, converged, timed_out, all_done, pct_bus, pct_valid
  );
endinterface
`default_nettype wire

// File: rtl/conv_race_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : conv_race_monitor
// Brief    : Watches NCH error channels on a shared epoch tick, records the
//            epoch each channel converges (with hold streak and timeout), then
//            computes integer percent speedup of every channel versus a
//            reference channel with one shared restoring divider.
// Revision : 1.0 - initial release
// ============================================================================
module conv_race_monitor #(
  parameter int NCH     = 2,
  parameter int EW      = 8,
  parameter int CW      = 12,
  parameter int SKIP    = 2,
  parameter int HOLD    = 1,
  parameter int MAX_CYC = 40,
  parameter int REF_CH  = 1
) (
  input wire                  clk,
  input wire                  rst,
  conv_race_monitor_if.slave  bus
);

  // Dividend/quotient width: (conv_ref - conv_i) * 100 needs CW+7 bits.
  localparam int c_DW   = CW + 7;
  localparam int c_CNTW = $clog2(c_DW);
  localparam int c_CHW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_ARMED = 2'd0,
    S_DONE  = 2'd1,
    S_TOUT  = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_LOAD = 2'd1,
    D_DIV  = 2'd2,
    D_FIN  = 2'd3
  } div_state_t;

  logic [CW-1:0]      r_epoch;
  logic [CW-1:0]      w_epoch_nxt;
  logic               w_sample;
  logic               w_at_max;
  logic [NCH-1:0]     w_done;
  logic [NCH-1:0]     w_tout;
  logic [NCH*CW-1:0]  w_conv_flat;
  logic               r_all_done;

  // Saturating epoch; the sample of this tick uses the post-increment value.
  assign w_epoch_nxt = (r_epoch == CW'(MAX_CYC)) ? r_epoch : r_epoch + 1'b1;
  assign w_sample    = bus.cycle_start && (w_epoch_nxt > CW'(SKIP));
  assign w_at_max    = (w_epoch_nxt == CW'(MAX_CYC));

  // Epoch counter; rearm beats a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_epoch <= '0;
    else if (bus.rearm)       r_epoch <= '0;
    else if (bus.cycle_start) r_epoch <= w_epoch_nxt;
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    ch_state_t      r_state;
    logic [3:0]     r_streak;
    logic [CW-1:0]  r_start;
    logic [CW-1:0]  r_conv;
    logic [EW-1:0]  w_err;
    logic           w_qual;
    logic [3:0]     w_streak_inc;
    logic           w_hold_met;

    assign w_err        = bus.err_bus[gi*EW +: EW];
    assign w_qual       = (w_err <= bus.conv_th);
    assign w_streak_inc = (r_streak == 4'hF) ? 4'hF : r_streak + 4'd1;
    assign w_hold_met   = (w_streak_inc >= 4'(HOLD));

    // Streak/convergence tracking; DONE wins over TOUT on the final sample.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state  <= S_ARMED;
        r_streak <= 4'd0;
        r_start  <= '0;
        r_conv   <= '0;
      end else if (bus.rearm) begin
        r_state  <= S_ARMED;
        r_streak <= 4'd0;
        r_start  <= '0;
        r_conv   <= '0;
      end else if (w_sample && (r_state == S_ARMED)) begin
        if (w_qual) begin
          r_streak <= w_streak_inc;
          if (r_streak == 4'd0) r_start <= w_epoch_nxt;
          if (w_hold_met) begin
            r_state <= S_DONE;
            r_conv  <= (r_streak == 4'd0) ? w_epoch_nxt : r_start;
          end else if (w_at_max) begin
            r_state <= S_TOUT;
          end
        end else begin
          r_streak <= 4'd0;
          if (w_at_max) r_state <= S_TOUT;
        end
      end
    end

    assign w_done[gi]                 = (r_state == S_DONE);
    assign w_tout[gi]                 = (r_state == S_TOUT);
    assign w_conv_flat[gi*CW +: CW]   = r_conv;
  end

  // All channels settled, one clock after the last leaves ARMED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_all_done <= 1'b0;
    else if (bus.rearm) r_all_done <= 1'b0;
    else                r_all_done <= &(w_done | w_tout);
  end

  // ---------------------------------------------------------------------
  // Shared restoring divider, one fixed-length slot per channel.
  // ---------------------------------------------------------------------
  div_state_t          r_dstate;
  logic [c_CHW-1:0]    r_ch;
  logic [c_CNTW-1:0]   r_cnt;
  logic [CW-1:0]       r_rem;
  logic [c_DW-1:0]     r_quo;
  logic [CW-1:0]       r_divisor;
  logic                r_skip;
  logic [NCH*7-1:0]    r_pct;
  logic                r_pct_valid;

  logic [CW-1:0]       w_conv_sel;
  logic [CW-1:0]       w_conv_ref;
  logic [CW-1:0]       w_diff;
  logic                w_ok;
  logic [c_DW-1:0]     w_dividend;
  logic [CW:0]         w_rem_sh;
  logic                w_ge;
  logic [CW-1:0]       w_rem_nxt;
  logic [c_DW-1:0]     w_quo_nxt;

  assign w_conv_sel = w_conv_flat[r_ch*CW +: CW];
  assign w_conv_ref = w_conv_flat[REF_CH*CW +: CW];
  assign w_ok       = w_done[r_ch] && w_done[REF_CH] && (w_conv_sel < w_conv_ref);
  assign w_diff     = w_conv_ref - w_conv_sel;
  assign w_dividend = {7'd0, w_diff} * c_DW'(100);

  // One restoring step: shift in next dividend bit, subtract if it fits.
  assign w_rem_sh  = {r_rem, r_quo[c_DW-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_nxt = w_ge ? CW'(w_rem_sh - {1'b0, r_divisor}) : w_rem_sh[CW-1:0];
  assign w_quo_nxt = {r_quo[c_DW-2:0], w_ge};

  // Divider sequencer: load, CW+7 steps (last one writes pct), next channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dstate    <= D_IDLE;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_skip      <= 1'b0;
      r_pct       <= '0;
      r_pct_valid <= 1'b0;
    end else if (bus.rearm) begin
      r_dstate    <= D_IDLE;
      r_ch        <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_skip      <= 1'b0;
      r_pct       <= '0;
      r_pct_valid <= 1'b0;
    end else begin
      case (r_dstate)
        D_IDLE, D_LOAD: begin
          if ((r_dstate == D_LOAD) || r_all_done) begin
            r_rem     <= '0;
            r_quo     <= w_ok ? w_dividend : '0;
            r_divisor <= w_conv_ref;
            r_skip    <= !w_ok;
            r_cnt     <= '0;
            r_dstate  <= D_DIV;
          end
        end
        D_DIV: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_CNTW'(c_DW - 1)) begin
            r_pct[r_ch*7 +: 7] <= r_skip ? 7'd0 : w_quo_nxt[6:0];
            r_cnt              <= '0;
            if (r_ch == c_CHW'(NCH - 1)) begin
              r_dstate    <= D_FIN;
              r_pct_valid <= 1'b1;
            end else begin
              r_ch     <= r_ch + 1'b1;
              r_dstate <= D_LOAD;
            end
          end
        end
        D_FIN:   r_dstate <= D_FIN;
        default: r_dstate <= D_IDLE;
      endcase
    end
  end

  assign bus.epoch        = r_epoch;
  assign bus.conv_cyc_bus = w_conv_flat;
  assign bus.converged    = w_done;
  assign bus.timed_out    = w_tout;
  assign bus.all_done     = r_all_done;
  assign bus.pct_bus      = r_pct;
  assign bus.pct_valid    = r_pct_valid;

endmodule
`default_nettype wire

// File: tb/tb_conv_race_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_conv_race_monitor
// Brief    : Two monitors (HOLD=1 and HOLD=3) fed identical stimulus; an
//            epoch-history model predicts every output each clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_race_monitor;
  localparam int NCH = 2, EW = 8, CW = 12, SKIP = 2, MAX_CYC = 40, REF_CH = 1;
  localparam int SLOT = CW + 8;
  localparam int NU = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_race_monitor_if #(.NCH(NCH), .EW(EW), .CW(CW)) bus0 ();
  conv_race_monitor_if #(.NCH(NCH), .EW(EW), .CW(CW)) bus1 ();

  conv_race_monitor #(.NCH(NCH), .EW(EW), .CW(CW), .SKIP(SKIP), .HOLD(1),
                      .MAX_CYC(MAX_CYC), .REF_CH(REF_CH))
    u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  conv_race_monitor #(.NCH(NCH), .EW(EW), .CW(CW), .SKIP(SKIP), .HOLD(3),
                      .MAX_CYC(MAX_CYC), .REF_CH(REF_CH))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [CW-1:0]     d_epoch [NU];
  logic [NCH*CW-1:0] d_conv  [NU];
  logic [NCH-1:0]    d_cv    [NU];
  logic [NCH-1:0]    d_to    [NU];
  logic              d_ad    [NU];
  logic              d_pv    [NU];
  logic [NCH*7-1:0]  d_pct   [NU];
  assign d_epoch[0] = bus0.epoch;        assign d_epoch[1] = bus1.epoch;
  assign d_conv[0]  = bus0.conv_cyc_bus; assign d_conv[1]  = bus1.conv_cyc_bus;
  assign d_cv[0]    = bus0.converged;    assign d_cv[1]    = bus1.converged;
  assign d_to[0]    = bus0.timed_out;    assign d_to[1]    = bus1.timed_out;
  assign d_ad[0]    = bus0.all_done;     assign d_ad[1]    = bus1.all_done;
  assign d_pv[0]    = bus0.pct_valid;    assign d_pv[1]    = bus1.pct_valid;
  assign d_pct[0]   = bus0.pct_bus;      assign d_pct[1]   = bus1.pct_bus;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;
  int t_ad    = -1;
  int t_pv    = -1;

  // ---------------- model: recorded samples per epoch ----------------
  int m_err [NCH][MAX_CYC+1];
  int m_th  [MAX_CYC+1];
  int m_epoch;
  int m_clk = 0;
  int m_settle [NU];
  int p0 [MAX_CYC+1];
  int p1 [MAX_CYC+1];

  function automatic int hold_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  // Earliest run of HOLD qualifying post-SKIP samples; result = run start.
  function automatic int conv_of(input int u, input int ch);
    int h;
    bit ok;
    h = hold_of(u);
    for (int e = SKIP + h; e <= m_epoch; e++) begin
      ok = 1'b1;
      for (int k = e - h + 1; k <= e; k++)
        if (m_err[ch][k] > m_th[k]) ok = 1'b0;
      if (ok) return e - h + 1;
    end
    return 0;
  endfunction

  function automatic bit resolved(input int u);
    bit r;
    r = 1'b1;
    for (int ch = 0; ch < NCH; ch++)
      if (conv_of(u, ch) == 0 && m_epoch < MAX_CYC) r = 1'b0;
    return r;
  endfunction

  function automatic int exp_pct(input int u, input int i);
    int c, r;
    if (i == REF_CH) return 0;
    c = conv_of(u, i);
    r = conv_of(u, REF_CH);
    if (c != 0 && r != 0 && c < r) return ((r - c) * 100) / r;
    return 0;
  endfunction

  task automatic m_reset();
    m_epoch = 0;
    for (int e = 0; e <= MAX_CYC; e++) begin
      m_th[e] = 0;
      for (int ch = 0; ch < NCH; ch++) m_err[ch][e] = 0;
    end
    for (int u = 0; u < NU; u++) m_settle[u] = -1;
  endtask

  // Model update on every clock edge / async reset.
  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_reset();
      end else begin
        m_clk++;
        if (bus0.rearm) begin
          m_reset();
        end else if (bus0.cycle_start && m_epoch < MAX_CYC) begin
          m_epoch++;
          for (int ch = 0; ch < NCH; ch++) m_err[ch][m_epoch] = int'(bus0.err_bus[ch*EW +: EW]);
          m_th[m_epoch] = int'(bus0.conv_th);
        end
        for (int u = 0; u < NU; u++)
          if (m_settle[u] < 0 && resolved(u)) m_settle[u] = m_clk;
      end
    end
  end

  task automatic chk(input string nm, input int u, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d (t=%0t)", nm, u, act, exp, $time);
    end
  endtask

  task automatic compare_unit(input int u);
    logic [NCH*CW-1:0] ec;
    logic [NCH-1:0]    ecv, eto;
    logic [NCH*7-1:0]  ep;
    bit ead, epv;
    int c;
    ec = '0; ecv = '0; eto = '0; ep = '0;
    ead = (m_settle[u] >= 0) && (m_clk >= m_settle[u] + 1);
    epv = (m_settle[u] >= 0) && (m_clk >= m_settle[u] + 1 + NCH*SLOT);
    for (int ch = 0; ch < NCH; ch++) begin
      c = conv_of(u, ch);
      ec[ch*CW +: CW] = CW'(c);
      ecv[ch] = (c != 0);
      eto[ch] = (c == 0) && (m_epoch >= MAX_CYC);
      if (m_settle[u] >= 0 && m_clk >= m_settle[u] + 1 + (ch + 1)*SLOT)
        ep[ch*7 +: 7] = 7'(exp_pct(u, ch));
    end
    chk("epoch",     u, d_epoch[u], m_epoch);
    chk("conv_cyc",  u, d_conv[u],  ec);
    chk("converged", u, d_cv[u],    ecv);
    chk("timed_out", u, d_to[u],    eto);
    chk("all_done",  u, d_ad[u],    ead);
    chk("pct_bus",   u, d_pct[u],   ep);
    chk("pct_valid", u, d_pv[u],    epv);
  endtask

  // Per-cycle comparison against the model, plus rise-time capture for dut0.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) for (int u = 0; u < NU; u++) compare_unit(u);
      if (d_ad[0] && t_ad < 0) t_ad = cyc;
      if (d_pv[0] && t_pv < 0) t_pv = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit cs, input bit re, input int th, input int e0, input int e1);
    bus0.cycle_start = cs;  bus1.cycle_start = cs;
    bus0.rearm = re;        bus1.rearm = re;
    bus0.conv_th = EW'(th); bus1.conv_th = EW'(th);
    bus0.err_bus = {EW'(e1), EW'(e0)};
    bus1.err_bus = {EW'(e1), EW'(e0)};
  endtask

  int cur_th = 5;

  task automatic run_ticks(input int first, input int last, input int gap);
    for (int e = first; e <= last; e++) begin
      @(negedge clk); drive(1'b1, 1'b0, cur_th, p0[e], p1[e]);
      @(negedge clk); drive(1'b0, 1'b0, cur_th, p0[e], p1[e]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic rearm_pulse(input bit with_tick);
    @(negedge clk); drive(with_tick, 1'b1, cur_th, 0, 0);
    @(negedge clk); drive(1'b0, 1'b0, cur_th, 0, 0);
  endtask

  task automatic fill(input int a, input int b);
    for (int e = 0; e <= MAX_CYC; e++) begin p0[e] = a; p1[e] = b; end
  endtask

  task automatic load_test1();
    fill(4, 5);
    p0[1] = 20; p0[2] = 14; p0[3] = 9;
    p1[1] = 20; p1[2] = 18; p1[3] = 15; p1[4] = 12; p1[5] = 8;
  endtask

  task automatic wait_pv(input int u, input int budget);
    int k;
    k = 0;
    while (!d_pv[u] && k < budget) begin @(negedge clk); k++; end
    if (!d_pv[u]) begin
      n_tests++; n_fail++;
      $display("FAIL wait_pct_valid dut%0d: not seen within %0d clocks", u, budget);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    drive(1'b0, 1'b0, 5, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("lit_reset_epoch", 0, d_epoch[0], 0);
    chk("lit_reset_pv",    0, d_pv[0],    0);

    // Basic race: ch0 converges at 4, reference ch1 at 6 -> 33 percent.
    cur_th = 5; load_test1(); t_ad = -1; t_pv = -1;
    run_ticks(1, 8, 3);
    wait_pv(1, 200);
    chk("lit_t1_conv0",   0, d_conv[0][0 +: CW],  4);
    chk("lit_t1_conv1",   0, d_conv[0][CW +: CW], 6);
    chk("lit_t1_pct0",    0, d_pct[0][6:0],       33);
    chk("lit_t1_pct1",    0, d_pct[0][13:7],      0);
    chk("lit_t1_latency", 0, t_pv - t_ad,         2*(12+8));
    chk("lit_t1_h3_conv1",1, d_conv[1][CW +: CW], 6);

    // Rearm coincident with a tick, then re-adaptation from 50 down to 10.
    cur_th = 12;
    rearm_pulse(1'b1);
    chk("lit_rearm_epoch", 0, d_epoch[0], 0);
    chk("lit_rearm_conv",  0, d_conv[0],  0);
    chk("lit_rearm_cv",    0, d_cv[0],    0);
    fill(10, 10);
    for (int e = 1; e <= 3; e++) p0[e] = 50;
    for (int e = 1; e <= 6; e++) p1[e] = 50;
    run_ticks(1, 1, 0);
    chk("lit_rearm_epoch1", 0, d_epoch[0], 1);
    run_ticks(2, 9, 3);
    wait_pv(1, 200);
    chk("lit_t4_pct0", 0, d_pct[0][6:0], 42);

    // Early qualifying samples are hidden by SKIP; both channels time out.
    cur_th = 5;
    rearm_pulse(1'b0);
    fill(30, 30); p0[1] = 3; p0[2] = 3; p1[1] = 3; p1[2] = 3;
    run_ticks(1, MAX_CYC, 1);
    chk("lit_t2_tout", 0, d_to[0], 3);
    chk("lit_t2_cv",   0, d_cv[0], 0);
    chk("lit_t2_ad",   0, d_ad[0], 1);
    wait_pv(0, 100);
    chk("lit_t2_pct",  0, d_pct[0], 0);

    // Hold streak broken at epoch 7; HOLD=3 unit must report epoch 8.
    rearm_pulse(1'b0);
    fill(4, 30);
    for (int e = 1; e <= 4; e++) p0[e] = 9;
    p0[7] = 9;
    run_ticks(1, MAX_CYC, 1);
    chk("lit_t3_h3_conv0", 1, d_conv[1][0 +: CW], 8);
    chk("lit_t3_h1_conv0", 0, d_conv[0][0 +: CW], 5);
    wait_pv(1, 100);

    // Rearm about 10 clocks into the division: no result for that epoch.
    rearm_pulse(1'b0);
    load_test1(); t_ad = -1;
    run_ticks(1, 6, 3);
    for (int k = 0; k < 100 && (t_ad < 0 || cyc - t_ad < 10); k++) @(negedge clk);
    rearm_pulse(1'b0);
    repeat (60) @(negedge clk);
    chk("lit_t5_pv",  0, d_pv[0],  0);
    chk("lit_t5_pct", 0, d_pct[0], 0);

    // New epoch, then an async reset between edges after ch0 converged.
    run_ticks(1, 4, 3);
    chk("lit_t6_pre_cv", 0, d_cv[0], 1);
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("lit_t6_async_epoch", 0, d_epoch[0], 0);
    chk("lit_t6_async_cv",    0, d_cv[0],    0);
    chk("lit_t6_async_conv",  0, d_conv[0],  0);
    @(negedge clk); rst = 1'b0;
    run_ticks(1, 8, 3);
    wait_pv(1, 200);
    chk("lit_t6_pct0",  0, d_pct[0][6:0],      33);
    chk("lit_t6_conv0", 0, d_conv[0][0 +: CW], 4);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
